// File: rtl/prince_fwd_rounds.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prince_fwd_rounds                                                          |
// | Iterative PRINCE forward half: rounds 1..NROUNDS on a 64-bit state, one    |
// | round (S, M', ShiftRows, ^RC_i, ^k1) per clock with valid/ready handshake. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prince_fwd_rounds #(
  parameter int NROUNDS = 5,
  parameter int CW      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_k1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [CW-1:0] C_LAST_RND = CW'(NROUNDS);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  localparam logic [63:0] C_RC1 = 64'h13198a2e03707344;
  localparam logic [63:0] C_RC2 = 64'ha4093822299f31d0;
  localparam logic [63:0] C_RC3 = 64'h082efa98ec4e6c89;
  localparam logic [63:0] C_RC4 = 64'h452821e638d01377;
  localparam logic [63:0] C_RC5 = 64'hbe5466cf34e90c6c;

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   st_q, st_d;
  logic [63:0]   key_q, key_d;
  logic          out_valid_q, out_valid_d;

  logic [63:0]   w_sb;
  logic [63:0]   w_mp;
  logic [63:0]   w_sr;
  logic [63:0]   w_rc;
  logic [63:0]   w_rnd;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hB;
      4'h1: y = 4'hF;
      4'h2: y = 4'h3;
      4'h3: y = 4'h2;
      4'h4: y = 4'hA;
      4'h5: y = 4'hC;
      4'h6: y = 4'h9;
      4'h7: y = 4'h1;
      4'h8: y = 4'h6;
      4'h9: y = 4'h7;
      4'hA: y = 4'h8;
      4'hB: y = 4'h0;
      4'hC: y = 4'hE;
      4'hD: y = 4'h5;
      4'hE: y = 4'hD;
      default: y = 4'h4;
    endcase
    return y;
  endfunction

  // S-layer: nibble n lives at bits [63-4n -: 4], nibble 0 is the MSB nibble.
  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign w_sb[63-4*n -: 4] = sbox(st_q[63-4*n -: 4]);
  end

  // M'-layer as diag(M0^, M1^, M1^, M0^) on 16-bit chunks. Each output bit is the
  // column parity of its chunk with the single masked-out term cancelled again.
  for (genvar c = 0; c < 4; c++) begin : g_mp_chunk
    localparam int SEL = ((c == 0) || (c == 3)) ? 0 : 1;
    logic [3:0] w_par;
    assign w_par = w_sb[63-16*c -: 4] ^ w_sb[59-16*c -: 4] ^
                   w_sb[55-16*c -: 4] ^ w_sb[51-16*c -: 4];
    for (genvar j = 0; j < 4; j++) begin : g_mp_nib
      for (genvar i = 0; i < 4; i++) begin : g_mp_bit
        localparam int K = (i - j - SEL + 8) % 4;
        assign w_mp[63-4*(4*c+j)-i] = w_par[3-i] ^ w_sb[63-4*(4*c+K)-i];
      end
    end
  end

  // ShiftRows permutation P[i] is 5*i mod 16.
  for (genvar i = 0; i < 16; i++) begin : g_shift_rows
    assign w_sr[63-4*i -: 4] = w_mp[63-4*((5*i)%16) -: 4];
  end

  always_comb begin
    w_rc = 64'h0;
    case (int'(cnt_q))
      1:       w_rc = C_RC1;
      2:       w_rc = C_RC2;
      3:       w_rc = C_RC3;
      4:       w_rc = C_RC4;
      5:       w_rc = C_RC5;
      default: w_rc = 64'h0;
    endcase
  end

  assign w_rnd = w_sr ^ w_rc ^ key_q;

  assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = st_q;

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in_data;
          key_d = in_k1;
          cnt_d = C_ONE;
          fsm_d = RUN;
        end
      end
      RUN: begin
        st_d = w_rnd;
        if (cnt_q == C_LAST_RND) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Handoff and next load share the same edge to keep NROUNDS+1 throughput.
          if (in_valid) begin
            st_d  = in_data;
            key_d = in_k1;
            cnt_d = C_ONE;
            fsm_d = RUN;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: begin
        fsm_d       = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prince_fwd_rounds.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prince_fwd_rounds                                                       |
// | Scoreboard bench: reference model results queued at load, monitor pops.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_prince_fwd_rounds;

  localparam int NR = 5;

  localparam logic [3:0] SBOX [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                       4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
  localparam int PERM [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  localparam logic [63:0] RC [6] = '{64'h0,
                                     64'h13198a2e03707344, 64'ha4093822299f31d0,
                                     64'h082efa98ec4e6c89, 64'h452821e638d01377,
                                     64'hbe5466cf34e90c6c};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_k1;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  longint      last_load_t = 0;

  prince_fwd_rounds #(.NROUNDS(NR), .CW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_k1    (in_k1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Reference: M' block (row j, column k) of chunk matrix M^(sel) is m_((j+k+sel) mod 4),
  // where m_t is the 4x4 identity with the diagonal entry t (counted from the MSB) zeroed.
  function automatic logic [63:0] ref_round(input logic [63:0] x, input int r, input logic [63:0] k);
    logic [3:0] a [16];
    logic [3:0] b [16];
    logic [63:0] y;
    int sel;
    for (int n = 0; n < 16; n++) a[n] = SBOX[x[63-4*n -: 4]];
    for (int c = 0; c < 4; c++) begin
      sel = (c == 0 || c == 3) ? 0 : 1;
      for (int j = 0; j < 4; j++) begin
        b[4*c+j] = 4'h0;
        for (int kk = 0; kk < 4; kk++)
          b[4*c+j] ^= a[4*c+kk] & ~(4'b1000 >> ((j + kk + sel) % 4));
      end
    end
    for (int i = 0; i < 16; i++) y[63-4*i -: 4] = b[PERM[i]];
    return y ^ RC[r] ^ k;
  endfunction

  function automatic logic [63:0] ref_model(input logic [63:0] d, input logic [63:0] k);
    logic [63:0] s = d;
    for (int r = 1; r <= NR; r++) s = ref_round(s, r, k);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: a result is consumed at the edge following a cycle with valid & ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [63:0] k);
    int t = 0;
    in_data  = d;
    in_k1    = k;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_timeout: in_ready stuck at %b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(ref_model(d, k));
    last_load_t = $time;
    #1 in_valid = 1'b0;
  endtask

  // Called at load edge +1: counts edges until out_valid, checking in_ready during RUN.
  task automatic check_latency();
    int n = 0;
    while (!out_valid && n < 20) begin
      chk("in_ready_in_run", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(NR));
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] d, k, held;
    longint prev_t;
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_k1     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(64'h0, 64'h0);
    check_latency();
    send(64'h0123456789abcdef, 64'hfedcba9876543210);
    check_latency();
    send(64'hffffffffffffffff, 64'hffffffffffffffff);
    check_latency();
    @(posedge clk);
    #1;

    // Backpressure: result must hold for 10 stalled cycles.
    out_ready = 1'b0;
    d = rnd64();
    k = rnd64();
    send(d, k);
    wait_out_valid();
    held = ref_model(d, k);
    repeat (10) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 64'(out_valid), 64'd0);

    // Back-to-back: in_valid stays high across the handoffs.
    send(rnd64(), rnd64());
    for (int b = 0; b < 3; b++) begin
      prev_t = last_load_t;
      send(rnd64(), rnd64());
      chk("b2b_period", 64'(last_load_t - prev_t), 64'd60);
    end
    wait_out_valid();
    @(posedge clk);
    #1;

    // Reset mid-RUN with counter at 3.
    send(rnd64(), rnd64());
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    void'(exp_q.pop_back());
    #2 rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(rnd64(), rnd64());
    check_latency();
    @(posedge clk);
    #1;

    // Input churn during RUN must not be captured.
    send(rnd64(), rnd64());
    repeat (3) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd64();
      in_k1    = rnd64();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_out_valid();
    @(posedge clk);
    #1;

    // Random blocks with random stall lengths.
    for (int b = 0; b < 4; b++) begin
      out_ready = 1'b0;
      send(rnd64(), rnd64());
      wait_out_valid();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
    end

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d pending", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/prince_fwd_rounds.md
Name: prince_fwd_rounds

Overview:
- Iterative engine for the PRINCE forward half. It performs rounds 1..NROUNDS on a 64-bit state, one round per clock.
- Each round applies, in order: S-layer, M'-layer (same matrix as the existing mixt block), ShiftRows, then XOR with RC_i and XOR with k1.
- Sits directly upstream of the mixt-based middle layer. Its output feeds the middle S/M'/S^-1 stage.
- Input whitening (k0 and RC0) is done upstream. This block starts at round 1.

Parameters:
- NROUNDS, 5, number of forward rounds executed (1..5). Uses RC1..RC_NROUNDS.
- CW, 3, round counter width. Must satisfy 2^CW > NROUNDS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a block.
- in_ready  out  1  engine can accept a block this cycle.
- in_data  in  64  whitened state.
- in_k1  in  64  round key k1, captured with in_data.
- out_valid  out  1  result held on out_data.
- out_ready  in  1  downstream accepts the result.
- out_data  out  64  state after round NROUNDS.

Behaviour:
- Bit order:
  - Nibble n = bits [63-4n:60-4n], so n=0 is the MSB nibble. This matches the convention used by the M'-layer.
  - Constants are XORed bit-for-bit: bit 63 of RC is XORed with bit 63 of the state.
- S-box, per nibble, hex, input 0..F: B F 3 2 A C 9 1 6 7 8 0 E 5 D 4.
- ShiftRows: out nibble i = in nibble P[i], with P = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- Round constants:
  - RC1=13198a2e03707344
  - RC2=a4093822299f31d0
  - RC3=082efa98ec4e6c89
  - RC4=452821e638d01377
  - RC5=be5466cf34e90c6c
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE, counter=0, state reg=0, key reg=0.
  - out_valid=0, out_data=0.
  - Reset asserted mid-RUN or in DONE aborts the block. No output is produced for it.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from the FSM state and out_ready.
- Load (in_valid & in_ready at an edge):
  - Capture in_data into the state reg and in_k1 into the key reg.
  - Set counter=1, go to RUN.
  - in_data and in_k1 may change after the load edge.
- RUN, each edge:
  - state reg <= round(state reg, RC[counter], key reg).
  - If counter==NROUNDS: go to DONE and set out_valid=1. Otherwise counter+1.
- out_data is the state reg; it is stable throughout DONE.
- Latency: the first out_valid=1 cycle follows NROUNDS edges after the load edge.
- Throughput: one block per NROUNDS+1 cycles when out_ready is held high.
- DONE:
  - Hold out_valid and out_data until out_ready=1.
  - At the edge with out_ready=1 and no new load: clear out_valid, go to IDLE.
  - At the edge with out_ready=1 and in_valid=1: the handoff completes and the new block loads on that same edge, going straight to RUN. out_valid drops to 0.
- in_valid during RUN is ignored (in_ready=0). Upstream holds the block.
- out_ready outside DONE has no effect.
- The counter never exceeds NROUNDS and never wraps.

Test Plan:
- Reset then single block:
  - Stimulus: rst_n low 3 cycles; in_data=0000000000000000, in_k1=0000000000000000, in_valid one cycle, out_ready=1.
  - Required: out_valid rises exactly 5 edges after the load edge; out_data equals the golden C model; in_ready=0 during RUN.
- Key and data variety:
  - Stimulus: in_data=0123456789abcdef, in_k1=fedcba9876543210; then in_data=ffffffffffffffff, in_k1=ffffffffffffffff.
  - Required: both outputs match the golden model. NROUNDS=1 build also matches the model.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Required: out_data stable and out_valid=1 throughout; in_ready=0; the result is released on the first out_ready=1 edge.
- Back-to-back:
  - Stimulus: in_valid and out_ready held 1, 4 random blocks.
  - Required: a new load on the same edge as each handoff; one result every 6 cycles; all results match the model, in order.
- Reset mid-RUN:
  - Stimulus: assert rst_n low at counter=3 for a half-cycle.
  - Required: out_valid=0, out_data=0 immediately; in_ready=1 after release; the next block's result is correct.
- in_valid toggling during RUN:
  - Required: no capture. in_data changes after the load edge do not alter the result.
